// File: rtl/des_key_pkg.sv
// Shared types, shift schedule, PC-1 wiring and 28-bit rotate helpers for the DES key sequencer.
package des_key_pkg;

  typedef logic [27:0] half_key_t;
  typedef logic [47:0] subkey_t;

  localparam logic [15:0] DES_SHIFTS = 16'h7EFC;

  typedef enum logic {KS_IDLE, KS_RUN} ks_state_e;

  // DES bit numbers (1 = MSB of the 64-bit key) feeding C and D, first entry = C/D bit 1
  localparam int PC1_C_TAB [28] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36};
  localparam int PC1_D_TAB [28] = '{63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  function automatic half_key_t pc1_c(input logic [63:0] key);
    half_key_t r;
    r = '0;
    for (int i = 0; i < 28; i++) r[5'(27 - i)] = key[6'(64 - PC1_C_TAB[i])];
    return r;
  endfunction

  function automatic half_key_t pc1_d(input logic [63:0] key);
    half_key_t r;
    r = '0;
    for (int i = 0; i < 28; i++) r[5'(27 - i)] = key[6'(64 - PC1_D_TAB[i])];
    return r;
  endfunction

  function automatic half_key_t rotl28(input half_key_t x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic half_key_t rotr28(input half_key_t x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_key_sequencer_permute_out.sv
// PC-2 compression of the 56-bit C/D state into a 48-bit round subkey.
// Pure wiring: zero latency, no flow control.
module permute_out (
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  // CD bit numbers (1 = cd[55]) selected for subkey bits 1..48
  localparam int PC2_TAB [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                  23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) subkey[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
  end

endmodule

// File: rtl/des_key_sequencer.sv
// Iterative DES subkey sequencer: first subkey 1 cycle after accept, one round per sk_valid/sk_ready
// handshake, holds under backpressure. Optional DES_KEY_ZEROIZE_EN wipes C/D at job end or abort.
module des_key_sequencer
  import des_key_pkg::*;
#(
  parameter logic [15:0] SHIFT_SCHEDULE = DES_SHIFTS,
  parameter int          ROUNDS         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        abort,
  output logic        busy,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  output logic        done
);

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  ks_state_e state;
  half_key_t c, d;
  half_key_t c_next, d_next, load_c, load_d;
  logic [3:0] cnt;
  logic       dec;
  logic       enc_two, dec_two, last;

  assign last    = (cnt == LAST_CNT);
  // Encrypt looks one round ahead; past round 15 there is no next subkey to form.
  assign enc_two = (cnt != 4'd15) && SHIFT_SCHEDULE[cnt + 4'd1];
  assign dec_two = SHIFT_SCHEDULE[4'd15 - cnt];

  assign c_next = dec ? rotr28(c, dec_two) : rotl28(c, enc_two);
  assign d_next = dec ? rotr28(d, dec_two) : rotl28(d, enc_two);

  // Decrypt starts at K16, whose cumulative rotation of 28 leaves PC-1 unchanged.
  assign load_c = decrypt ? pc1_c(key_in) : rotl28(pc1_c(key_in), 1'b0);
  assign load_d = decrypt ? pc1_d(key_in) : rotl28(pc1_d(key_in), 1'b0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= KS_IDLE;
      c     <= '0;
      d     <= '0;
      cnt   <= '0;
      dec   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        KS_IDLE: begin
          if (start && !abort) begin
            c     <= load_c;
            d     <= load_d;
            dec   <= decrypt;
            cnt   <= '0;
            state <= KS_RUN;
          end
`ifdef DES_KEY_ZEROIZE_EN
          else begin
            c   <= '0;
            d   <= '0;
            dec <= 1'b0;
          end
`endif
        end
        KS_RUN: begin
          if (abort) begin
            state <= KS_IDLE;
`ifdef DES_KEY_ZEROIZE_EN
            c   <= '0;
            d   <= '0;
            dec <= 1'b0;
`endif
          end else if (sk_ready) begin
            cnt <= cnt + 4'd1;
            c   <= c_next;
            d   <= d_next;
            if (last) begin
              state <= KS_IDLE;
              done  <= 1'b1;
`ifdef DES_KEY_ZEROIZE_EN
              c   <= '0;
              d   <= '0;
              dec <= 1'b0;
`endif
            end
          end
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

  assign busy     = (state == KS_RUN);
  assign sk_valid = (state == KS_RUN);
  assign sk_last  = (state == KS_RUN) && last;
  assign sk_round = dec ? (4'd15 - cnt) : cnt;

  permute_out u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

endmodule
